// File: rtl/bsg_pkg.sv
// Shared types and CTRL register bit positions for the BSG transmitter register bridge.
package bsg_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } bsg_br_state_t;

    localparam int CTRL_TXEN     = 0;
    localparam int CTRL_INTMSK   = 1;
    localparam int CTRL_INTFLAG  = 2;
    localparam int CTRL_STAT_LSB = 3;

endpackage

// File: rtl/bsg_reg_bridge.sv
// Bus-to-register bridge: CTRL register plus NUM_CH data registers, with a one-deep
// pending buffer that defers data writes while the transmit core is busy.
module bsg_reg_bridge
    import bsg_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 8,
    parameter int NUM_CH    = 2,
    parameter int BASE_ADDR = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     bus_valid,
    input  logic                     bus_write,
    input  logic [ADDR_W-1:0]        bus_addr,
    input  logic [DATA_W-1:0]        bus_wdata,
    output logic                     bus_ready,
    output logic [DATA_W-1:0]        bus_rdata,
    output logic                     bus_rvalid,
    input  logic                     tx_busy,
    input  logic [3:0]               tx_status,
    output logic                     tx_enable,
    output logic [NUM_CH*DATA_W-1:0] data_out,
    output logic                     irq
);

    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [ADDR_W-1:0] LP_BASE = ADDR_W'(BASE_ADDR);

    bsg_br_state_t     r_state;
    logic              r_txen;
    logic              r_intmsk;
    logic              r_intflag;
    logic              r_busy_prev;
    logic              r_irq;
    logic [DATA_W-1:0] r_data [NUM_CH];
    logic [CH_W-1:0]   r_pend_ch;
    logic [DATA_W-1:0] r_pend_data;
    logic [DATA_W-1:0] r_rdata;
    logic              r_rvalid;

    logic [ADDR_W-1:0] w_off;
    logic              w_accept;
    logic              w_is_ctrl;
    logic              w_is_data;
    logic [CH_W-1:0]   w_ch;
    logic              w_wr_ctrl;
    logic              w_wr_data;
    logic              w_rd;
    logic              w_busy_fall;
    logic              w_commit;
    logic [DATA_W-1:0] w_rd_val;

    // Unsigned wrap: addresses below BASE_ADDR land far above NUM_CH and decode as out of range.
    assign w_off       = bus_addr - LP_BASE;
    assign w_accept    = bus_valid & bus_ready;
    assign w_is_ctrl   = (w_off == '0);
    assign w_wr_ctrl   = w_accept & bus_write & w_is_ctrl;
    assign w_wr_data   = w_accept & bus_write & w_is_data;
    assign w_rd        = w_accept & ~bus_write;
    assign w_busy_fall = r_busy_prev & ~tx_busy;
    assign w_commit    = (r_state == HOLD) & ~tx_busy;

    always_comb begin
        w_ch      = '0;
        w_is_data = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (w_off == ADDR_W'(i + 1)) begin
                w_ch      = CH_W'(i);
                w_is_data = 1'b1;
            end
        end
    end

    always_comb begin
        w_rd_val = '0;
        if (w_is_ctrl) begin
            w_rd_val[CTRL_TXEN]           = r_txen;
            w_rd_val[CTRL_INTMSK]         = r_intmsk;
            w_rd_val[CTRL_INTFLAG]        = r_intflag;
            w_rd_val[CTRL_STAT_LSB +: 5]  = {tx_status, tx_busy};
        end else if (w_is_data) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (w_ch == CH_W'(i)) begin
                    w_rd_val = r_data[i];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_txen      <= 1'b0;
            r_intmsk    <= 1'b0;
            r_intflag   <= 1'b0;
            r_busy_prev <= 1'b0;
            r_irq       <= 1'b0;
            r_pend_ch   <= '0;
            r_pend_data <= '0;
            r_rdata     <= '0;
            r_rvalid    <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                r_data[i] <= '0;
            end
        end else begin
            r_busy_prev <= tx_busy;
            r_irq       <= r_intflag & r_intmsk;
            r_rvalid    <= w_rd;
            if (w_rd) begin
                r_rdata <= w_rd_val;
            end

            if (w_wr_ctrl) begin
                r_txen   <= bus_wdata[CTRL_TXEN];
                r_intmsk <= bus_wdata[CTRL_INTMSK];
            end

            // A completion edge in the same cycle as a W1C keeps the flag set.
            if (w_busy_fall) begin
                r_intflag <= 1'b1;
            end else if (w_wr_ctrl && bus_wdata[CTRL_INTFLAG]) begin
                r_intflag <= 1'b0;
            end

            case (r_state)
                IDLE: begin
                    if (w_wr_data && tx_busy) begin
                        r_pend_ch   <= w_ch;
                        r_pend_data <= bus_wdata;
                        r_state     <= HOLD;
                    end else if (w_wr_data) begin
                        for (int i = 0; i < NUM_CH; i++) begin
                            if (w_ch == CH_W'(i)) begin
                                r_data[i] <= bus_wdata;
                            end
                        end
                    end
                end
                HOLD: begin
                    if (w_commit) begin
                        for (int i = 0; i < NUM_CH; i++) begin
                            if (r_pend_ch == CH_W'(i)) begin
                                r_data[i] <= r_pend_data;
                            end
                        end
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_comb begin
        data_out = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            data_out[i*DATA_W +: DATA_W] = r_data[i];
        end
    end

    assign bus_ready  = (r_state == IDLE);
    assign bus_rdata  = r_rdata;
    assign bus_rvalid = r_rvalid;
    assign tx_enable  = r_txen;
    assign irq        = r_irq;

endmodule

// File: tb/tb_bsg_reg_bridge.sv
// Self-checking bench for bsg_reg_bridge: randomized bus traffic against a register-level model.
module tb_bsg_reg_bridge;

    localparam int DATA_W    = 8;
    localparam int ADDR_W    = 8;
    localparam int NUM_CH    = 2;
    localparam int BASE_ADDR = 10;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic                     bus_valid = 1'b0;
    logic                     bus_write = 1'b0;
    logic [ADDR_W-1:0]        bus_addr = '0;
    logic [DATA_W-1:0]        bus_wdata = '0;
    logic                     bus_ready;
    logic [DATA_W-1:0]        bus_rdata;
    logic                     bus_rvalid;
    logic                     tx_busy = 1'b0;
    logic [3:0]               tx_status = 4'h0;
    logic                     tx_enable;
    logic [NUM_CH*DATA_W-1:0] data_out;
    logic                     irq;

    int errors = 0;
    int checks = 0;

    // Reference model: architectural register contents.
    logic [DATA_W-1:0] m_data [NUM_CH];
    logic m_txen, m_msk, m_flag, m_busy;

    bsg_reg_bridge #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_CH(NUM_CH), .BASE_ADDR(BASE_ADDR)
    ) dut (
        .clk(clk), .rst(rst),
        .bus_valid(bus_valid), .bus_write(bus_write), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_ready(bus_ready), .bus_rdata(bus_rdata),
        .bus_rvalid(bus_rvalid), .tx_busy(tx_busy), .tx_status(tx_status),
        .tx_enable(tx_enable), .data_out(data_out), .irq(irq)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

    function automatic logic [NUM_CH*DATA_W-1:0] exp_dout();
        logic [NUM_CH*DATA_W-1:0] v;
        for (int i = 0; i < NUM_CH; i++) v[i*DATA_W +: DATA_W] = m_data[i];
        return v;
    endfunction

    function automatic logic [DATA_W-1:0] exp_ctrl();
        return {tx_status, m_busy, m_flag, m_msk, m_txen};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NUM_CH; i++) m_data[i] = '0;
        m_txen = 1'b0; m_msk = 1'b0; m_flag = 1'b0;
    endtask

    task automatic model_ctrl_write(input logic [DATA_W-1:0] d);
        m_txen = d[0];
        m_msk  = d[1];
        if (d[2]) m_flag = 1'b0;
    endtask

    task automatic model_data_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        int off;
        off = (int'(a) - BASE_ADDR) & ((1 << ADDR_W) - 1);
        if (off >= 1 && off <= NUM_CH) m_data[off-1] = d;
    endtask

    // Drivers: called at a negedge, return at a negedge.
    task automatic set_busy(input logic b);
        if (m_busy && !b) m_flag = 1'b1;
        tx_busy = b;
        m_busy  = b;
    endtask

    task automatic bus_wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        bus_valid = 1'b1; bus_write = 1'b1; bus_addr = a; bus_wdata = d;
        @(negedge clk);
        bus_valid = 1'b0; bus_write = 1'b0;
    endtask

    task automatic bus_rd(input logic [ADDR_W-1:0] a, output logic [DATA_W-1:0] d, output logic v);
        bus_valid = 1'b1; bus_write = 1'b0; bus_addr = a;
        @(negedge clk);
        bus_valid = 1'b0;
        d = bus_rdata;
        v = bus_rvalid;
    endtask

    task automatic test_reset();
        logic [DATA_W-1:0] d; logic v;
        rst = 1'b1; tx_busy = 1'b0; m_busy = 1'b0; bus_valid = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (data_out !== '0) begin errors++; $display("FAIL reset_dout got %h exp 0", data_out); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %b exp 0", irq); end
        checks++; if (bus_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", bus_ready); end
        checks++; if (bus_rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid got %b exp 0", bus_rvalid); end
        checks++; if (tx_enable !== 1'b0) begin errors++; $display("FAIL reset_txen got %b exp 0", tx_enable); end
        rst = 1'b0;
        model_reset();
        bus_rd(ADDR_W'(BASE_ADDR), d, v);
        checks++; if (v !== 1'b1 || d !== 8'h00) begin errors++; $display("FAIL reset_ctrl_rd got v=%b d=%h exp v=1 d=00", v, d); end
    endtask

    task automatic test_idle_write();
        logic [DATA_W-1:0] d, dv; logic v; int ch;
        bus_wr(8'd11, 8'hA5);
        model_data_write(8'd11, 8'hA5);
        checks++; if (data_out !== exp_dout()) begin errors++; $display("FAIL idle_wr_a5 got %h exp %h", data_out, exp_dout()); end
        bus_rd(8'd11, d, v);
        checks++; if (v !== 1'b1 || d !== 8'hA5) begin errors++; $display("FAIL idle_rd_a5 got v=%b d=%h exp v=1 d=a5", v, d); end
        @(negedge clk);
        checks++; if (bus_rvalid !== 1'b0) begin errors++; $display("FAIL rvalid_pulse got %b exp 0", bus_rvalid); end
        for (int k = 0; k < 6; k++) begin
            ch = $urandom_range(0, NUM_CH-1);
            dv = DATA_W'($urandom);
            bus_wr(ADDR_W'(BASE_ADDR + 1 + ch), dv);
            model_data_write(ADDR_W'(BASE_ADDR + 1 + ch), dv);
            checks++; if (data_out !== exp_dout()) begin errors++; $display("FAIL idle_wr_rand got %h exp %h", data_out, exp_dout()); end
            ch = $urandom_range(0, NUM_CH-1);
            bus_rd(ADDR_W'(BASE_ADDR + 1 + ch), d, v);
            checks++; if (v !== 1'b1 || d !== m_data[ch]) begin errors++; $display("FAIL idle_rd_rand ch%0d got v=%b d=%h exp v=1 d=%h", ch, v, d, m_data[ch]); end
        end
    endtask

    task automatic test_ctrl_rw();
        logic [DATA_W-1:0] d, w; logic v;
        for (int k = 0; k < 5; k++) begin
            tx_status = 4'($urandom);
            set_busy(1'($urandom));
            w = DATA_W'($urandom);
            w[2] = 1'b0;
            bus_wr(ADDR_W'(BASE_ADDR), w);
            model_ctrl_write(w);
            checks++; if (tx_enable !== m_txen) begin errors++; $display("FAIL ctrl_txen got %b exp %b", tx_enable, m_txen); end
            bus_rd(ADDR_W'(BASE_ADDR), d, v);
            checks++; if (v !== 1'b1 || d !== exp_ctrl()) begin errors++; $display("FAIL ctrl_rd got v=%b d=%h exp v=1 d=%h", v, d, exp_ctrl()); end
            checks++; if (irq !== (m_flag & m_msk)) begin errors++; $display("FAIL ctrl_irq got %b exp %b", irq, m_flag & m_msk); end
        end
        set_busy(1'b0);
        @(negedge clk);
        tx_status = 4'h0;
    endtask

    task automatic test_busy_write();
        logic [NUM_CH*DATA_W-1:0] old;
        logic [DATA_W-1:0] dv; int ch, hold;
        set_busy(1'b1);
        @(negedge clk);
        old = exp_dout();
        bus_wr(8'd12, 8'h3C);
        checks++; if (bus_ready !== 1'b0) begin errors++; $display("FAIL busy_ready got %b exp 0", bus_ready); end
        checks++; if (data_out !== old) begin errors++; $display("FAIL busy_hold_dout got %h exp %h", data_out, old); end
        bus_valid = 1'b1; bus_write = 1'b0; bus_addr = 8'd12;
        repeat (2) begin
            @(negedge clk);
            checks++; if (bus_rvalid !== 1'b0 || bus_ready !== 1'b0 || data_out !== old) begin
                errors++; $display("FAIL busy_rd_blocked got rv=%b rdy=%b dout=%h exp rv=0 rdy=0 dout=%h", bus_rvalid, bus_ready, data_out, old);
            end
        end
        set_busy(1'b0);
        @(negedge clk);
        model_data_write(8'd12, 8'h3C);
        checks++; if (data_out !== exp_dout() || bus_ready !== 1'b1 || bus_rvalid !== 1'b0) begin
            errors++; $display("FAIL busy_commit got dout=%h rdy=%b rv=%b exp dout=%h rdy=1 rv=0", data_out, bus_ready, bus_rvalid, exp_dout());
        end
        @(negedge clk);
        bus_valid = 1'b0;
        checks++; if (bus_rvalid !== 1'b1 || bus_rdata !== 8'h3C) begin
            errors++; $display("FAIL busy_held_rd got rv=%b d=%h exp rv=1 d=3c", bus_rvalid, bus_rdata);
        end
        for (int k = 0; k < 4; k++) begin
            ch = $urandom_range(0, NUM_CH-1);
            dv = DATA_W'($urandom);
            hold = $urandom_range(1, 4);
            set_busy(1'b1);
            @(negedge clk);
            old = exp_dout();
            bus_wr(ADDR_W'(BASE_ADDR + 1 + ch), dv);
            repeat (hold) @(negedge clk);
            checks++; if (data_out !== old || bus_ready !== 1'b0) begin
                errors++; $display("FAIL busy_rand_hold got dout=%h rdy=%b exp dout=%h rdy=0", data_out, bus_ready, old);
            end
            set_busy(1'b0);
            @(negedge clk);
            model_data_write(ADDR_W'(BASE_ADDR + 1 + ch), dv);
            checks++; if (data_out !== exp_dout() || bus_ready !== 1'b1) begin
                errors++; $display("FAIL busy_rand_commit got dout=%h rdy=%b exp dout=%h rdy=1", data_out, bus_ready, exp_dout());
            end
        end
    endtask

    task automatic test_interrupt();
        logic [DATA_W-1:0] d; logic v;
        bus_wr(ADDR_W'(BASE_ADDR), 8'h04); model_ctrl_write(8'h04);
        bus_wr(ADDR_W'(BASE_ADDR), 8'h03); model_ctrl_write(8'h03);
        @(negedge clk);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_pre got %b exp 0", irq); end
        set_busy(1'b1);
        @(negedge clk);
        set_busy(1'b0);
        @(negedge clk);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_lag got %b exp 0", irq); end
        @(negedge clk);
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_set got %b exp 1", irq); end
        bus_rd(ADDR_W'(BASE_ADDR), d, v);
        checks++; if (v !== 1'b1 || d !== exp_ctrl()) begin errors++; $display("FAIL irq_flag_rd got d=%h exp %h", d, exp_ctrl()); end
        bus_wr(ADDR_W'(BASE_ADDR), 8'h07); model_ctrl_write(8'h07);
        @(negedge clk);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_w1c got %b exp 0", irq); end
        bus_rd(ADDR_W'(BASE_ADDR), d, v);
        checks++; if (d !== exp_ctrl()) begin errors++; $display("FAIL irq_w1c_rd got d=%h exp %h", d, exp_ctrl()); end
        bus_wr(ADDR_W'(BASE_ADDR), 8'h01); model_ctrl_write(8'h01);
        set_busy(1'b1);
        @(negedge clk);
        set_busy(1'b0);
        repeat (3) begin
            @(negedge clk);
            checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_masked got %b exp 0", irq); end
        end
        bus_rd(ADDR_W'(BASE_ADDR), d, v);
        checks++; if (d !== exp_ctrl()) begin errors++; $display("FAIL irq_masked_rd got d=%h exp %h", d, exp_ctrl()); end
    endtask

    task automatic test_w1c_collision();
        logic [DATA_W-1:0] d; logic v;
        bus_wr(ADDR_W'(BASE_ADDR), 8'h04); model_ctrl_write(8'h04);
        set_busy(1'b1);
        @(negedge clk);
        bus_valid = 1'b1; bus_write = 1'b1; bus_addr = ADDR_W'(BASE_ADDR); bus_wdata = 8'h04;
        tx_busy = 1'b0; m_busy = 1'b0;
        @(negedge clk);
        bus_valid = 1'b0; bus_write = 1'b0;
        m_txen = 1'b0; m_msk = 1'b0; m_flag = 1'b1;
        bus_rd(ADDR_W'(BASE_ADDR), d, v);
        checks++; if (v !== 1'b1 || d !== exp_ctrl()) begin errors++; $display("FAIL w1c_collision got d=%h exp %h", d, exp_ctrl()); end
        bus_wr(ADDR_W'(BASE_ADDR), 8'h02); model_ctrl_write(8'h02);
        @(negedge clk);
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL w1c_zero_irq got %b exp 1", irq); end
        bus_rd(ADDR_W'(BASE_ADDR), d, v);
        checks++; if (d !== exp_ctrl()) begin errors++; $display("FAIL w1c_zero_rd got d=%h exp %h", d, exp_ctrl()); end
    endtask

    task automatic test_out_of_range();
        logic [ADDR_W-1:0] addrs [6];
        logic [DATA_W-1:0] d; logic v;
        addrs[0] = 8'd9;
        addrs[1] = 8'd13;
        addrs[2] = 8'd0;
        addrs[3] = 8'd255;
        addrs[4] = ADDR_W'($urandom_range(BASE_ADDR + NUM_CH + 1, 255));
        addrs[5] = ADDR_W'($urandom_range(0, BASE_ADDR - 1));
        for (int k = 0; k < 6; k++) begin
            bus_wr(addrs[k], DATA_W'($urandom));
            model_data_write(addrs[k], 8'h00);
            checks++; if (data_out !== exp_dout() || tx_enable !== m_txen) begin
                errors++; $display("FAIL oor_wr a=%0d got dout=%h txen=%b exp dout=%h txen=%b", addrs[k], data_out, tx_enable, exp_dout(), m_txen);
            end
            bus_rd(addrs[k], d, v);
            checks++; if (v !== 1'b1 || d !== 8'h00) begin errors++; $display("FAIL oor_rd a=%0d got v=%b d=%h exp v=1 d=00", addrs[k], v, d); end
        end
        bus_rd(ADDR_W'(BASE_ADDR), d, v);
        checks++; if (d !== exp_ctrl()) begin errors++; $display("FAIL oor_ctrl got d=%h exp %h", d, exp_ctrl()); end
    endtask

    task automatic test_reset_in_hold();
        logic [DATA_W-1:0] d; logic v;
        bus_wr(ADDR_W'(BASE_ADDR + 2), 8'h5A); model_data_write(ADDR_W'(BASE_ADDR + 2), 8'h5A);
        set_busy(1'b1);
        @(negedge clk);
        bus_wr(ADDR_W'(BASE_ADDR + 1), DATA_W'($urandom_range(1, 255)));
        checks++; if (bus_ready !== 1'b0) begin errors++; $display("FAIL hold_rst_pre got rdy=%b exp 0", bus_ready); end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        checks++; if (bus_ready !== 1'b1 || data_out !== exp_dout() || irq !== 1'b0 || tx_enable !== 1'b0) begin
            errors++; $display("FAIL hold_rst got rdy=%b dout=%h irq=%b txen=%b exp rdy=1 dout=%h irq=0 txen=0", bus_ready, data_out, irq, tx_enable, exp_dout());
        end
        @(negedge clk);
        set_busy(1'b0);
        repeat (2) @(negedge clk);
        checks++; if (data_out !== exp_dout() || bus_ready !== 1'b1) begin
            errors++; $display("FAIL hold_rst_dropped got dout=%h rdy=%b exp dout=%h rdy=1", data_out, bus_ready, exp_dout());
        end
        bus_rd(ADDR_W'(BASE_ADDR + 1), d, v);
        checks++; if (v !== 1'b1 || d !== m_data[0]) begin errors++; $display("FAIL hold_rst_rd got v=%b d=%h exp v=1 d=%h", v, d, m_data[0]); end
    endtask

    initial begin
        m_busy = 1'b0;
        model_reset();
        test_reset();
        test_idle_write();
        test_ctrl_rw();
        test_busy_write();
        test_interrupt();
        test_w1c_collision();
        test_out_of_range();
        test_reset_in_hold();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
